// File: rtl/mix_pkg.sv
// Shared definitions for the mixing-state digest slice.
//   MIX_NUM_WORDS : words per generator state beat
//   MIX_WIDTH     : bits per word and signature width
//   digest_state_t: digest FSM states
//   rotl1         : rotate-left-by-one used by the signature fold
package mix_pkg;

    localparam int MIX_NUM_WORDS = 8;
    localparam int MIX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } digest_state_t;

    function automatic logic [MIX_WIDTH-1:0] rotl1(input logic [MIX_WIDTH-1:0] v);
        return {v[MIX_WIDTH-2:0], v[MIX_WIDTH-1]};
    endfunction

endpackage

// File: rtl/mix_lane_sum.sv
// Combinational sum of all words of one state beat, wrapping mod 2^WIDTH.
// Ports:
//   words : NUM_WORDS packed words, word i at [i*WIDTH +: WIDTH]
//   sum   : wrapped sum of all words (carries out of the top bit dropped)
module mix_lane_sum
    import mix_pkg::*;
#(
    parameter int NUM_WORDS = MIX_NUM_WORDS,
    parameter int WIDTH     = MIX_WIDTH
) (
    input  logic [NUM_WORDS*WIDTH-1:0] words,
    output logic [WIDTH-1:0]           sum
);

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            sum = sum + words[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mix_state_digest.sv
// Folds a programmed number of generator state beats into one rolling
// signature and presents it on a held valid/ready output.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle pulse, starts a run (IDLE only)
//   in_valid/in_ready    : input beat handshake
//   in_data              : NUM_WORDS packed words per beat
//   dig_valid/dig_ready  : digest handshake, held until taken
//   dig_data             : final signature
//   busy                 : run in progress (ACCUM or DONE)
// The signature fold uses mix_pkg::rotl1, so WIDTH must equal MIX_WIDTH.
module mix_state_digest
    import mix_pkg::*;
#(
    parameter int               NUM_WORDS = MIX_NUM_WORDS,
    parameter int               WIDTH     = MIX_WIDTH,
    parameter int               BEATS     = 16,
    parameter logic [WIDTH-1:0] SEED      = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_WORDS*WIDTH-1:0] in_data,
    output logic                       dig_valid,
    input  logic                       dig_ready,
    output logic [WIDTH-1:0]           dig_data,
    output logic                       busy
);

    localparam int CW = $clog2(BEATS + 1);
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

    digest_state_t    state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_q;
    logic             s1_valid;
    logic             accept;

    mix_lane_sum #(
        .NUM_WORDS (NUM_WORDS),
        .WIDTH     (WIDTH)
    ) u_lane_sum (
        .words (in_data),
        .sum   (lane_sum)
    );

    // in_ready is a pure decode of registered state and counter, so the
    // upstream sees no combinational path from its own in_valid.
    assign in_ready  = (state == ACCUM) && (cnt < BEATS_C);
    assign accept    = in_valid && in_ready;
    assign dig_valid = (state == DONE);
    assign dig_data  = sig;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sig      <= SEED;
            lane_q   <= '0;
            s1_valid <= 1'b0;
        end else begin
            // Stage 1: register the lane sum of each accepted beat.
            s1_valid <= accept;
            if (accept) begin
                lane_q <= lane_sum;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        sig   <= SEED;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Stage 2: fold the previous beat into the signature.
                    if (s1_valid) begin
                        sig <= WIDTH'(rotl1(MIX_WIDTH'(sig))) ^ lane_q;
                    end
                    // Counter full with the last sum in flight: this edge
                    // performs the final fold.
                    if ((cnt == BEATS_C) && s1_valid) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (dig_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_state_digest.sv
module tb_mix_state_digest;

    localparam int N = 4;
    localparam int          BEATS_T [N] = '{2, 1, 1, 4};
    localparam logic [31:0] SEED_T  [N] = '{32'h0000_0000, 32'h8000_0001,
                                           32'h0000_0000, 32'h0000_0000};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start     [N];
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic [255:0] in_data   [N];
    logic         dig_valid [N];
    logic         dig_ready [N];
    logic [31:0]  dig_data  [N];
    logic         busy      [N];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  exp_q  [$];
    logic [255:0] beat_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mix_state_digest #(
            .NUM_WORDS (8),
            .WIDTH     (32),
            .BEATS     (BEATS_T[g]),
            .SEED      (SEED_T[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .dig_valid (dig_valid[g]),
            .dig_ready (dig_ready[g]),
            .dig_data  (dig_data[g]),
            .busy      (busy[g])
        );
    end

    // Independent reference model of the fold.
    function automatic logic [31:0] m_sum(input logic [255:0] d);
        logic [31:0] s = 32'h0;
        for (int w = 0; w < 8; w++) s = s + d[w*32 +: 32];
        return s;
    endfunction

    function automatic logic [31:0] m_rotl(input logic [31:0] v);
        return (v << 1) | (v >> 31);
    endfunction

    function automatic logic [255:0] rand_beat();
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Drives every queued beat back-to-back; returns the model digest.
    task automatic feed(input int i, input logic [31:0] seed, output logic [31:0] expd);
        logic [255:0] b;
        expd = seed;
        while (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            in_valid[i] = 1'b1;
            in_data[i]  = b;
            chk("in_ready_beat", 32'(in_ready[i]), 32'd1);
            expd = m_rotl(expd) ^ m_sum(b);
            @(negedge clk);
        end
        in_valid[i] = 1'b0;
        in_data[i]  = '0;
    endtask

    task automatic wait_digest(input int i, output int waited);
        waited = 0;
        while (!dig_valid[i] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("dig_valid_arrives", 32'(dig_valid[i]), 32'd1);
    endtask

    task automatic take_digest(input int i);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            e = 'x;
        end else begin
            e = exp_q.pop_front();
        end
        chk("dig_data", dig_data[i], e);
        dig_ready[i] = 1'b1;
        @(negedge clk);
        dig_ready[i] = 1'b0;
        chk("idle_busy", 32'(busy[i]), 32'd0);
        chk("idle_dig_valid", 32'(dig_valid[i]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  expd;
        logic [255:0] b;
        logic [255:0] run6 [4];
        int           waited;
        int           pat [7] = '{1, 0, 0, 1, 1, 0, 1};

        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; dig_ready[i] = 1'b0; in_data[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values of every instance.
        for (int i = 0; i < N; i++) begin
            chk("rst_in_ready", 32'(in_ready[i]), 32'd0);
            chk("rst_dig_valid", 32'(dig_valid[i]), 32'd0);
            chk("rst_dig_data", dig_data[i], SEED_T[i]);
            chk("rst_busy", 32'(busy[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 1: BEATS=2, SEED=0, sums 8 then 28 -> 0x0C, latency check.
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'd1;
        beat_q.push_back(b);
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'(w);
        beat_q.push_back(b);
        chk("in_ready_idle", 32'(in_ready[0]), 32'd0);
        do_start(0);
        chk("busy_accum", 32'(busy[0]), 32'd1);
        feed(0, SEED_T[0], expd);
        exp_q.push_back(32'h0000_000C);
        chk("lat_not_early", 32'(dig_valid[0]), 32'd0);
        wait_digest(0, waited);
        chk("lat_cycles", 32'(waited), 32'd1);
        take_digest(0);

        // 2: BEATS=1, SEED=0x80000001, zero beat -> rotate wraps MSB.
        do_start(1);
        beat_q.push_back('0);
        feed(1, SEED_T[1], expd);
        exp_q.push_back(32'h0000_0003);
        wait_digest(1, waited);
        take_digest(1);

        // 3: BEATS=1, SEED=0, all-ones words -> sum wraps to 0xFFFFFFF8.
        do_start(2);
        beat_q.push_back('1);
        feed(2, SEED_T[2], expd);
        exp_q.push_back(32'hFFFF_FFF8);
        wait_digest(2, waited);
        take_digest(2);

        // 4: digest held under back-pressure; start ignored while DONE.
        do_start(0);
        beat_q.push_back(rand_beat());
        beat_q.push_back(rand_beat());
        feed(0, SEED_T[0], expd);
        exp_q.push_back(expd);
        wait_digest(0, waited);
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = rand_beat();
            start[0]    = c[0];
            @(negedge clk);
            chk("hold_dig_valid", 32'(dig_valid[0]), 32'd1);
            chk("hold_dig_data", dig_data[0], expd);
            chk("hold_in_ready", 32'(in_ready[0]), 32'd0);
            chk("hold_busy", 32'(busy[0]), 32'd1);
        end
        in_valid[0] = 1'b0;
        start[0]    = 1'b1;  // coincides with the handshake -> dropped
        take_digest(0);
        start[0] = 1'b0;
        @(negedge clk);
        chk("start_dropped_busy", 32'(busy[0]), 32'd0);
        chk("start_dropped_in_ready", 32'(in_ready[0]), 32'd0);

        // 5: BEATS=4 with in_valid gaps; 5th beat refused.
        do_start(3);
        expd = SEED_T[3];
        for (int s = 0; s < 7; s++) begin
            b = rand_beat();
            in_valid[3] = pat[s][0];
            in_data[3]  = b;
            chk("gap_in_ready", 32'(in_ready[3]), 32'd1);
            if (pat[s] != 0) expd = m_rotl(expd) ^ m_sum(b);
            @(negedge clk);
        end
        exp_q.push_back(expd);
        in_valid[3] = 1'b1;
        in_data[3]  = rand_beat();
        chk("fifth_in_ready", 32'(in_ready[3]), 32'd0);
        @(negedge clk);
        chk("fifth_in_ready_late", 32'(in_ready[3]), 32'd0);
        in_valid[3] = 1'b0;
        wait_digest(3, waited);
        take_digest(3);

        // 6: async reset after 2 of 4 beats, then a clean rerun.
        for (int k = 0; k < 4; k++) run6[k] = rand_beat();
        do_start(3);
        beat_q.push_back(run6[0]);
        beat_q.push_back(run6[1]);
        feed(3, SEED_T[3], expd);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready[3]), 32'd0);
        chk("arst_dig_valid", 32'(dig_valid[3]), 32'd0);
        chk("arst_busy", 32'(busy[3]), 32'd0);
        chk("arst_dig_data", dig_data[3], SEED_T[3]);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy[3]), 32'd0);
        do_start(3);
        for (int k = 0; k < 4; k++) beat_q.push_back(run6[k]);
        feed(3, SEED_T[3], expd);
        exp_q.push_back(expd);
        wait_digest(3, waited);
        take_digest(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mix_state_digest.md
Name: mix_state_digest

Overview:
- Downstream consumer of the 8x32-bit mixing-state generator. The generator's full state vector is presented as one beat per clock.
- Each beat's eight words are folded into a single 32-bit rolling signature over a programmed number of beats.
- The final digest is then presented on a valid/ready output for the bench to compare, so long mixing runs are checked by one compare instead of per-cycle dumps.
- Real sequential block: input handshake, 2-stage fold pipeline, beat counter, 3-state FSM, held output handshake.

Parameters:
NUM_WORDS, 8, words per input beat (one per state register)
WIDTH, 32, bits per word and width of the signature
BEATS, 16, beats folded per digest; legal range 1..65535
SEED, 32'h0000_0000, signature value loaded on start

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a digest run (honoured in IDLE only)
in_valid  input  1  upstream beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  NUM_WORDS*WIDTH  packed state words; word i at [i*WIDTH +: WIDTH]
dig_valid  output  1  digest available
dig_ready  input  1  consumer takes the digest
dig_data  output  WIDTH  final signature
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE; sig=SEED; beat counter=0; stage-1 valid=0.
- Reset values of outputs: in_ready=0, dig_valid=0, dig_data=SEED, busy=0.
- Reset mid-run discards the run entirely; no partial digest is emitted.
- FSM IDLE:
  - start=1 -> ACCUM, loading sig=SEED and counter=0.
  - in_valid is ignored; in_ready=0.
- FSM ACCUM:
  - in_ready = (counter < BEATS).
  - A beat is accepted when in_valid & in_ready; accepting increments the counter.
  - The FSM moves to DONE on the edge where the final sig update happens, i.e. when counter==BEATS and stage-1 valid is high.
  - After BEATS beats are accepted, in_ready=0 even if in_valid=1.
  - start is ignored.
- FSM DONE:
  - dig_valid=1 and dig_data=sig, both held stable until dig_ready.
  - dig_valid & dig_ready -> IDLE, same edge.
  - start is ignored.
  - If start and the dig handshake fall in the same cycle, the start is dropped; a fresh start is required in IDLE.
- Stage 1 (registered on accept): lane_sum = sum of all NUM_WORDS words, mod 2^WIDTH; wrap-around is discarded and no carry is kept.
- Stage 2 (on stage-1 valid): sig <= rotl(sig,1) ^ lane_sum.
- Latency: if the final beat is accepted at edge k, dig_valid is high in the cycle after edge k+1.
- Back-to-back beats every cycle are supported at full throughput; in_valid gaps simply stall the counter.
- in_data is sampled only when accepted; its value is don't-care otherwise.

Decomposition:
- Shared package mix_pkg holds:
  - constants MIX_NUM_WORDS=8 and MIX_WIDTH=32;
  - enum digest_state_t {IDLE, ACCUM, DONE};
  - function rotl1.
- One sub-module, mix_lane_sum: combinational adder tree over NUM_WORDS words, WIDTH-bit wrap, instantiated ahead of the stage-1 register.
- FSM, counter and sig stay in the top.

Test Plan:
1. BEATS=2, SEED=0; start; beat1 all words=1 (sum 8), beat2 words 0..7 (sum 28), back-to-back -> dig_valid in the cycle after the edge following beat2 acceptance, dig_data=32'h0000000C.
2. BEATS=1, SEED=32'h80000001; beat of all zeros -> dig_data=32'h00000003 (rotate wraps the MSB to the LSB).
3. BEATS=1, SEED=0; beat of all words=32'hFFFFFFFF -> dig_data=32'hFFFFFFF8 (sum wraps mod 2^32).
4. BEATS=2; hold dig_ready=0 for 5 cycles with in_valid=1 and start pulses -> dig_valid and dig_data stable, in_ready=0, no restart; after the dig_ready handshake, IDLE with busy=0.
5. BEATS=4; toggle in_valid 1,0,0,1,1,0,1 -> exactly 4 beats accepted, digest matches the software model, and a 5th in_valid sees in_ready=0.
6. Assert rst_n=0 asynchronously (mid-clock) after 2 of 4 beats -> in_ready, dig_valid and busy go 0 immediately; after release, a new start with 4 beats gives a digest equal to a clean run.
